// File: rtl/snake_move_scheduler.sv
// Snake game move scheduler: paces moves from a tick divider, validates the next head
// against walls and the body (scanned one segment per cycle), then commits the shift.
module snake_move_scheduler #(
  parameter int TICK_DIV = 10000000,
  parameter int MAX_LEN  = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       grow_req,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [3:0] rd_idx,
  output logic [3:0] head_x,
  output logic [3:0] head_y,
  output logic [4:0] len,
  output logic       body_init,
  output logic       shift_en,
  output logic       shift_grow,
  output logic       q_Ini,
  output logic       q_Run,
  output logic       q_Lose
);
  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

  typedef enum logic [5:0] {
    S_INI    = 6'b000001,
    S_WAIT   = 6'b000010,
    S_CALC   = 6'b000100,
    S_SCAN   = 6'b001000,
    S_COMMIT = 6'b010000,
    S_LOSE   = 6'b100000
  } state_t;

  typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

  state_t        state;
  dir_t          dir;
  dir_t          pend_dir;
  dir_t          btn_dir;
  dir_t          opp_dir;
  logic [CW-1:0] cnt;
  logic          moving;
  logic          tick_pend;
  logic          tick;
  logic          grow;
  logic          btn_any;
  logic          accept;
  logic          wall;
  logic          hit;
  logic [3:0]    nx;
  logic [3:0]    ny;
  logic [3:0]    nhx;
  logic [3:0]    nhy;
  logic [4:0]    scan_last;

  // One-hot state bits drive the LEDs directly so they stay flop outputs
  assign q_Ini  = state[0];
  assign q_Run  = |state[4:1];
  assign q_Lose = state[5];

  always_comb begin
    btn_dir = DIR_R;
    if (BtnU)      btn_dir = DIR_U;
    else if (BtnD) btn_dir = DIR_D;
    else if (BtnL) btn_dir = DIR_L;
    case (dir)
      DIR_U:   opp_dir = DIR_D;
      DIR_D:   opp_dir = DIR_U;
      DIR_L:   opp_dir = DIR_R;
      default: opp_dir = DIR_L;
    endcase
  end

  assign btn_any   = BtnU | BtnD | BtnL | BtnR;
  assign accept    = q_Run & btn_any & (btn_dir != opp_dir);
  assign tick      = q_Run & moving & (cnt == TICK_LAST);
  assign scan_last = grow ? (len - 5'd1) : (len - 5'd2);
  assign hit       = (rd_x == nhx) && (rd_y == nhy);

  always_comb begin
    nx   = head_x;
    ny   = head_y;
    wall = 1'b0;
    case (pend_dir)
      DIR_U:   if (head_y == 4'd0)  wall = 1'b1; else ny = head_y - 4'd1;
      DIR_D:   if (head_y == 4'd15) wall = 1'b1; else ny = head_y + 4'd1;
      DIR_L:   if (head_x == 4'd0)  wall = 1'b1; else nx = head_x - 4'd1;
      default: if (head_x == 4'd15) wall = 1'b1; else nx = head_x + 4'd1;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_INI;
      cnt        <= '0;
      tick_pend  <= 1'b0;
      moving     <= 1'b0;
      dir        <= DIR_R;
      pend_dir   <= DIR_R;
      rd_idx     <= '0;
      shift_en   <= 1'b0;
      shift_grow <= 1'b0;
      body_init  <= 1'b0;
      head_x     <= 4'd4;
      head_y     <= 4'd8;
      len        <= 5'd3;
      grow       <= 1'b0;
      nhx        <= '0;
      nhy        <= '0;
    end else begin
      body_init  <= 1'b0;
      shift_en   <= 1'b0;
      shift_grow <= 1'b0;
      // An equal-direction press still starts the snake but leaves pend_dir alone
      if (accept) begin
        moving <= 1'b1;
        if (btn_dir != dir) pend_dir <= btn_dir;
      end
      if (q_Run && moving) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick && (state != S_WAIT)) tick_pend <= 1'b1;
      case (state)
        S_INI: begin
          if (!body_init) begin
            body_init <= 1'b1;
            head_x    <= 4'd4;
            head_y    <= 4'd8;
            len       <= 5'd3;
            dir       <= DIR_R;
            pend_dir  <= DIR_R;
            moving    <= 1'b0;
            cnt       <= '0;
            tick_pend <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick || tick_pend) begin
            tick_pend <= 1'b0;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          dir    <= pend_dir;
          nhx    <= nx;
          nhy    <= ny;
          grow   <= grow_req;
          rd_idx <= '0;
          state  <= wall ? S_LOSE : S_SCAN;
        end
        S_SCAN: begin
          if (hit) begin
            state <= S_LOSE;
          end else if ({1'b0, rd_idx} == scan_last) begin
            // Head and length update as COMMIT is entered so the datapath sees the
            // new head on head_x/head_y while shift_en is high.
            state      <= S_COMMIT;
            shift_en   <= 1'b1;
            shift_grow <= grow;
            head_x     <= nhx;
            head_y     <= nhy;
            if (grow && (len < LEN_MAX)) len <= len + 5'd1;
          end else begin
            rd_idx <= rd_idx + 4'd1;
          end
        end
        S_COMMIT: state <= S_WAIT;
        S_LOSE:   state <= S_LOSE;
        default:  state <= S_INI;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed move table, hand-written corner sequences,
// and random play checked against a queue-based game model.
module tb_snake_move_scheduler;
  localparam int TD = 64;
  localparam int ML = 16;
  localparam logic [3:0] B_N = 4'b0000;
  localparam logic [3:0] B_U = 4'b1000;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_R = 4'b0001;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic       grow_req = 1'b0;
  logic [3:0] rd_x, rd_y, rd_idx, head_x, head_y;
  logic [4:0] len;
  logic       body_init, shift_en, shift_grow, q_Ini, q_Run, q_Lose;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int commit_cyc;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  snake_move_scheduler #(.TICK_DIV(TD), .MAX_LEN(ML)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .grow_req(grow_req), .rd_x(rd_x), .rd_y(rd_y), .rd_idx(rd_idx),
    .head_x(head_x), .head_y(head_y), .len(len),
    .body_init(body_init), .shift_en(shift_en), .shift_grow(shift_grow),
    .q_Ini(q_Ini), .q_Run(q_Run), .q_Lose(q_Lose)
  );

  // Body memory the scheduler scans
  logic [3:0] bx [16];
  logic [3:0] by [16];
  assign rd_x = bx[rd_idx];
  assign rd_y = by[rd_idx];
  always @(posedge Clk) begin
    if (body_init) begin
      for (int i = 0; i < 16; i++) begin
        bx[i] <= (i < 5) ? 4'(4 - i) : 4'd0;
        by[i] <= 4'd8;
      end
    end else if (shift_en) begin
      bx[0] <= head_x;
      by[0] <= head_y;
      for (int i = 1; i < 16; i++) begin
        bx[i] <= bx[i-1];
        by[i] <= by[i-1];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Game model: body as a queue, head at index 0; dirs 0=U 1=D 2=L 3=R
  int mq_x[$];
  int mq_y[$];
  int mdir, mpend, mlen;
  bit mmov;
  int opp [4] = '{1, 0, 3, 2};

  function automatic void model_reset();
    mq_x = '{4, 3, 2};
    mq_y = '{8, 8, 8};
    mdir = 3; mpend = 3; mlen = 3; mmov = 0;
  endfunction

  function automatic void model_press(logic [3:0] b);
    int p;
    if (b == 4'b0) return;
    p = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    if (p == opp[mdir]) return;
    mmov = 1;
    if (p != mdir) mpend = p;
  endfunction

  function automatic bit model_move(bit g);
    int nx, ny, lim;
    mdir = mpend;
    nx = mq_x[0] + ((mdir == 2) ? -1 : (mdir == 3) ? 1 : 0);
    ny = mq_y[0] + ((mdir == 0) ? -1 : (mdir == 1) ? 1 : 0);
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) return 1;
    lim = g ? mlen : mlen - 1;
    for (int i = 0; i < lim; i++)
      if (mq_x[i] == nx && mq_y[i] == ny) return 1;
    mq_x.push_front(nx);
    mq_y.push_front(ny);
    if (g && mlen < ML) mlen++;
    while (mq_x.size() > mlen) begin
      void'(mq_x.pop_back());
      void'(mq_y.pop_back());
    end
    return 0;
  endfunction

  typedef struct {
    bit         rst;
    logic [3:0] btn;
    bit         g;
    int         ex, ey, elen;
    bit         elose;
    bit         chk_int;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, logic [3:0] b, bit g, int ex, int ey, int el, bit lo, bit ci);
    vec_t v;
    v.rst = r; v.btn = b; v.g = g; v.ex = ex; v.ey = ey; v.elen = el; v.elose = lo; v.chk_int = ci;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    {BtnU, BtnD, BtnL, BtnR} = 4'b0;
    grow_req = 1'b0;
    @(negedge Clk);
    chk("rst_leds", {q_Ini, q_Run, q_Lose}, 3'b100);
    chk("rst_pulses", {body_init, shift_en, rd_idx}, 6'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("init_pulse", {q_Ini, body_init, q_Run}, 3'b110);
    @(negedge Clk);
    chk("init_run", {q_Ini, body_init, q_Run, q_Lose}, 4'b0010);
    chk("init_head_len", {head_x, head_y, len}, {4'd4, 4'd8, 5'd3});
  endtask

  task automatic run_move(input logic [3:0] b, input logic g, output bit commit, output bit lose, output bit tmo);
    commit = 0; lose = 0; tmo = 1;
    @(negedge Clk);
    {BtnU, BtnD, BtnL, BtnR} = b;
    grow_req = g;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      {BtnU, BtnD, BtnL, BtnR} = 4'b0;
      if (shift_en) begin commit = 1; tmo = 0; commit_cyc = cyc; break; end
      if (q_Lose)   begin lose = 1;   tmo = 0; break; end
    end
  endtask

  task automatic check_move(input string tag, input bit commit, input bit lose, input bit tmo,
                            input bit elose, input int ex, input int ey, input int el, input bit g);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_lose"}, lose, elose);
    chk({tag, "_commit"}, commit, !elose);
    chk({tag, "_head"}, {head_x, head_y}, {4'(ex), 4'(ey)});
    chk({tag, "_len"}, len, el);
    if (commit) chk({tag, "_shift_grow"}, shift_grow, g);
  endtask

  task automatic lose_hold(input string tag);
    int se, nl;
    logic [7:0] h;
    se = 0; nl = 0; h = {head_x, head_y};
    @(negedge Clk); BtnU = 1'b1;
    @(negedge Clk); BtnU = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge Clk);
      if (shift_en) se++;
      if (!q_Lose) nl++;
    end
    chk({tag, "_hold_shift"}, se, 0);
    chk({tag, "_hold_state"}, nl, 0);
    chk({tag, "_hold_head"}, {head_x, head_y}, h);
  endtask

  initial begin
    bit commit, lose, tmo, elose, found;
    int last, se;
    logic [3:0] b;
    logic g;

    // Run right to the east wall; the L press is opposite and discarded
    add(1, B_R, 0, 5, 8, 3, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, (k == 3) ? B_L : B_N, 0, 5 + k, 8, 3, 0, 1);
    add(0, B_N, 0, 15, 8, 3, 1, 0);
    // U beats R when simultaneous; D then opposite to UP
    add(1, B_U | B_R, 0, 4, 7, 3, 0, 0);
    add(0, B_D, 0, 4, 6, 3, 0, 1);
    // Moving into the tail cell: legal without grow, fatal with grow
    add(1, B_R, 1, 5, 8, 4, 0, 0);
    add(0, B_U, 0, 5, 7, 4, 0, 0);
    add(0, B_L, 0, 4, 7, 4, 0, 1);
    add(0, B_D, 0, 4, 8, 4, 0, 1);
    add(1, B_R, 1, 5, 8, 4, 0, 0);
    add(0, B_U, 0, 5, 7, 4, 0, 0);
    add(0, B_L, 0, 4, 7, 4, 0, 1);
    add(0, B_D, 1, 4, 7, 4, 1, 0);
    // len=5 then U, L, D runs into an old head segment
    add(1, B_R, 1, 5, 8, 4, 0, 0);
    add(0, B_N, 1, 6, 8, 5, 0, 0);
    add(0, B_U, 0, 6, 7, 5, 0, 0);
    add(0, B_L, 0, 5, 7, 5, 0, 0);
    add(0, B_D, 0, 5, 7, 5, 1, 0);
    // Grow for 14 moves to saturate, ending on the west wall
    add(1, B_R, 1, 5, 8, 4, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, (k == 1) ? B_U : B_N, 1, 5, 8 - k, 4 + k, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, (k == 1) ? B_L : B_N, 1, 5 - k, 0, (12 + k > ML) ? ML : 12 + k, 0, 0);
    add(0, B_N, 1, 0, 0, 16, 1, 0);

    repeat (2) @(negedge Clk);
    do_reset();

    // Idle: an opposite press does not start motion
    @(negedge Clk); BtnL = 1'b1;
    @(negedge Clk); BtnL = 1'b0;
    se = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (shift_en) se++;
    end
    chk("idle_shift", se, 0);
    chk("idle_head", {head_x, head_y, q_Run}, {4'd4, 4'd8, 1'b1});

    last = -1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin do_reset(); last = -1; end
      run_move(tbl[i].btn, tbl[i].g, commit, lose, tmo);
      check_move($sformatf("vec%0d", i), commit, lose, tmo, tbl[i].elose,
                 tbl[i].ex, tbl[i].ey, tbl[i].elen, tbl[i].g);
      if (commit && tbl[i].chk_int && last >= 0)
        chk($sformatf("vec%0d_interval", i), commit_cyc - last, TD);
      if (commit) last = commit_cyc;
      if (lose) lose_hold($sformatf("vec%0d", i));
    end

    do_reset();

    // Reset during the last SCAN cycle must suppress the commit
    @(negedge Clk); BtnR = 1'b1;
    found = 0; se = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      BtnR = 1'b0;
      if (shift_en) se++;
      if (rd_idx == 4'd1) begin found = 1; break; end
    end
    chk("midscan_found", found, 1);
    Reset = 1'b1;
    @(negedge Clk);
    if (shift_en) se++;
    chk("midscan_shift", se, 0);
    chk("midscan_ini", q_Ini, 1);
    do_reset();

    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      model_reset();
      for (int m = 0; m < 20; m++) begin
        if (m == 0) begin
          case ($urandom_range(0, 2))
            0:       b = B_U;
            1:       b = B_D;
            default: b = B_R;
          endcase
        end else begin
          b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : B_N;
        end
        g = ($urandom_range(0, 3) == 0);
        model_press(b);
        elose = model_move(g);
        run_move(b, g, commit, lose, tmo);
        check_move($sformatf("rnd%0d_%0d", ep, m), commit, lose, tmo, elose,
                   mq_x[0], mq_y[0], mlen, g);
        if (elose || lose || tmo) break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_move_scheduler.md
SNAKE_MOVE_SCHEDULER -- requirements
Module: snake_move_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 10000000, clock cycles per snake move; legal range 32 or more.
REQ-002 Parameter MAX_LEN, default 16, maximum body length in segments.
REQ-003 Clk  in  1  system clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 BtnU, BtnD, BtnL, BtnR  in  1 each  debounced single-cycle direction pulses.
REQ-006 grow_req  in  1  food eaten; sampled in CALC.
REQ-007 rd_x, rd_y  in  4 each  combinational body-memory read data for rd_idx.
REQ-008 rd_idx  out  4  body segment index being scanned.
REQ-009 head_x, head_y  out  4 each  current head coordinate.
REQ-010 len  out  5  current body length.
REQ-011 body_init  out  1  one-cycle pulse; datapath loads the initial body.
REQ-012 shift_en, shift_grow  out  1 each  one-cycle commit; datapath writes next head at index 0, shifts body, keeps tail if shift_grow=1.
REQ-013 q_Ini, q_Run, q_Lose  out  1 each  one-hot state LEDs; q_Run=1 in WAIT/CALC/SCAN/COMMIT.

Function
REQ-014 States: INI, WAIT, CALC, SCAN, COMMIT, LOSE.
REQ-015 INI: assert body_init, load head=(4,8), len=3, dir=RIGHT, moving=0; go to WAIT next cycle.
REQ-016 Direction buttons are latched into pend_dir in any run state, priority U>D>L>R when simultaneous.
REQ-017 A press opposite to the current dir is discarded; a press equal to dir is ignored.
REQ-018 First accepted press sets moving=1; before that, no move sequence starts.
REQ-019 Tick counter runs 0..TICK_DIV-1 only while in run states and moving=1; wraps to 0 and raises tick at TICK_DIV-1.
REQ-020 A tick arriving outside WAIT sets tick_pend; tick_pend is consumed on the next WAIT.
REQ-021 WAIT -> CALC on tick or tick_pend.
REQ-022 CALC: dir<=pend_dir; compute next head (U: y-1, D: y+1, L: x-1, R: x+1); latch grow=grow_req.
REQ-023 Wall rule: next coordinate leaving 0..15 (x=0 moving L, x=15 moving R, y=0 moving U, y=15 moving D) -> LOSE; no wrap-around.
REQ-024 CALC -> SCAN otherwise, rd_idx=0.
REQ-025 SCAN compares the next head to segment rd_idx each cycle, with rd_idx 0..len-2 when grow=0 and 0..len-1 when grow=1; a match -> LOSE.
REQ-026 SCAN completion without a match -> COMMIT; SCAN takes at most MAX_LEN cycles.
REQ-027 COMMIT: pulse shift_en, shift_grow=grow; head<=next head.
REQ-028 COMMIT increments len if grow=1 and len<MAX_LEN; len saturates at MAX_LEN, and the tail is dropped when saturated.
REQ-029 COMMIT -> WAIT.
REQ-030 LOSE is terminal; shift_en stays 0, buttons are ignored, and the tick counter holds; exit only by Reset.
REQ-031 Outputs are registered; shift_en and body_init are never high in the same cycle.

Reset
REQ-032 Reset forces state=INI, counter=0, tick_pend=0, moving=0, pend_dir=RIGHT, rd_idx=0, shift_en=0, and body_init=0 (pulsed on the first post-reset cycle), with q_Ini=1 and q_Run=q_Lose=0.
REQ-033 Reset asserted mid-SCAN or mid-COMMIT aborts the move with no shift_en pulse, and the design restarts from INI.

Verification (TICK_DIV=64)
REQ-034 Reset pulse -> q_Ini=1 for one cycle with body_init=1, then q_Run=1, head=(4,8), len=3.
REQ-035 No button for 500 cycles -> no shift_en pulse and head stays (4,8).
REQ-036 BtnR pulse -> shift_en every 64 cycles, head_x increments by 1 per move; after 11 moves (x=15) the next tick produces q_Lose=1 and no further shift_en.
REQ-037 BtnL while dir=RIGHT -> discarded and head_x keeps incrementing; BtnU and BtnR in the same cycle -> dir=UP.
REQ-038 Body model with len=5, then U, L, D presses each one move apart -> the SCAN match at the old head segment gives q_Lose=1 with no shift_en on that move.
REQ-039 grow_req=1 held for 14 moves -> len saturates at 16, shift_grow=1 on every commit; Reset in LOSE gives q_Ini=1, len=3.
